// File: rtl/audio_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : audio_stream_ctrl_if
//  Purpose  : CODEC ADC-read / DAC-write handshake bundle. The controller
//             drives the strobes and DAC data (master); the CODEC drives the
//             ready flags and ADC data (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface audio_stream_ctrl_if #(
  parameter int DW = 24
);
  logic          read_ready;
  logic          write_ready;
  logic [DW-1:0] readdata_left;
  logic [DW-1:0] readdata_right;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata_left;
  logic [DW-1:0] writedata_right;

  modport master (
    input  read_ready, write_ready, readdata_left, readdata_right,
    output read, write, writedata_left, writedata_right
  );

  modport slave (
    output read_ready, write_ready, readdata_left, readdata_right,
    input  read, write, writedata_left, writedata_right
  );
endinterface
`default_nettype wire

// File: rtl/audio_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : audio_stream_ctrl
//  Purpose  : Sequences single-cycle CODEC read/write strobes and buffers
//             stereo pairs in a small FIFO. Primes the FIFO before playback,
//             zero-fills starved DAC writes and counts overruns/underruns.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_stream_ctrl #(
  parameter int DW          = 24,
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     enable,
  audio_stream_ctrl_if.master      codec,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              overrun_count,
  output logic [15:0]              underrun_count,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] c_depth       = PW'(DEPTH);
  localparam logic [PW-1:0] c_prime_level = PW'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdl_q, wdl_d, wdr_q, wdr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2*DW-1:0] mem_q [DEPTH];
  logic [2*DW-1:0] mem_d [DEPTH];
  logic [15:0]     ovr_q, ovr_d, und_q, und_d;

  logic [PW-1:0]   fill, fill_next;
  logic [2*DW-1:0] head;
  logic            active, empty, full;
  logic            wr_req, push, pop, push_ok, overrun, underrun;

  // FIFO status and the per-edge push/pop/overrun/underrun decisions
  always_comb begin
    fill      = wr_ptr_q - rd_ptr_q;
    empty     = (fill == '0);
    full      = (fill == c_depth);
    active    = enable && (state_q != ST_IDLE);
    head      = mem_q[rd_ptr_q[AW-1:0]];
    wr_req    = active && codec.write_ready && !write_q;
    pop       = wr_req && (state_q == ST_RUN) && !empty;
    underrun  = wr_req && (state_q == ST_RUN) && empty;
    // A pending read strobe means the pair is captured on this edge;
    // a full FIFO only accepts it when the head leaves on the same edge.
    push      = active && read_q;
    push_ok   = push && (!full || pop);
    overrun   = push && full && !pop;
    fill_next = (wr_ptr_q + PW'(push_ok)) - (rd_ptr_q + PW'(pop));
  end

  // Strobe generation, DAC data load, pointer and counter updates
  always_comb begin
    read_d   = active && codec.read_ready && !read_q;
    write_d  = wr_req;
    wdl_d    = wdl_q;
    wdr_d    = wdr_q;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovr_d    = ovr_q;
    und_d    = und_q;
    if (wr_req) begin
      // Look-ahead head: the popped pair is loaded on the pop edge itself.
      {wdl_d, wdr_d} = pop ? head : '0;
    end
    if (overrun && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
    if (underrun && (und_q != 16'hFFFF)) und_d = und_q + 16'd1;
    if (!enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // FIFO storage write port
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = {codec.readdata_left, codec.readdata_right};
  end

  // Sequencer: IDLE -> PRIME -> RUN, back to PRIME on underrun
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (fill_next >= c_prime_level) state_d = ST_RUN;
        ST_RUN:   if (underrun) state_d = ST_PRIME;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register; asynchronous reset also kills any in-flight strobe
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      wdl_q    <= '0;
      wdr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= '0;
      und_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      write_q  <= write_d;
      wdl_q    <= wdl_d;
      wdr_q    <= wdr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
      mem_q    <= mem_d;
    end
  end

  assign codec.read            = read_q;
  assign codec.write           = write_q;
  assign codec.writedata_left  = wdl_q;
  assign codec.writedata_right = wdr_q;
  assign fill_level            = fill;
  assign overrun_count         = ovr_q;
  assign underrun_count        = und_q;
  assign state                 = state_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_stream_ctrl
//  Purpose  : Self-checking bench for audio_stream_ctrl. Emulates the CODEC
//             handshake, tracks accepted ADC pairs in a scoreboard queue and
//             compares DAC writes, state, fill level and counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_stream_ctrl;

  localparam int DW = 24;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  fill_level;
  logic [15:0] overrun_count;
  logic [15:0] underrun_count;
  logic [1:0]  st;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*DW-1:0] sb_q [$];

  audio_stream_ctrl_if #(.DW(DW)) io ();

  audio_stream_ctrl #(.DW(DW), .DEPTH(8), .PRIME_LEVEL(4)) dut (
    .CLOCK_50       (clk),
    .resetn         (resetn),
    .enable         (enable),
    .codec          (io),
    .fill_level     (fill_level),
    .overrun_count  (overrun_count),
    .underrun_count (underrun_count),
    .state          (st)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit          is_dac;
    logic [23:0] l;
    logic [23:0] r;
    bit          exp_zero;
    logic [1:0]  exp_state;
    logic [3:0]  exp_fill;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: strobe timeout, got none, expected strobe", name);
  endtask

  // Offer one ADC pair and let the controller consume it
  task automatic adc_send(input logic [23:0] l, input logic [23:0] r, output bit ok);
    int n = 0;
    io.read_ready = 1'b1;
    io.readdata_left = l;
    io.readdata_right = r;
    do begin tick(); n++; end while (!io.read && n < 20);
    io.read_ready = 1'b0;
    ok = io.read;
    if (!ok) timeout("adc_send");
    else tick();
  endtask

  // Request one DAC write and return the data presented with the strobe
  task automatic dac_take(output logic [23:0] l, output logic [23:0] r, output bit ok);
    int n = 0;
    io.write_ready = 1'b1;
    do begin tick(); n++; end while (!io.write && n < 20);
    io.write_ready = 1'b0;
    ok = io.write;
    l = io.writedata_left;
    r = io.writedata_right;
    if (!ok) timeout("dac_take");
  endtask

  // Arrange the capture edge of a read to coincide with a write load
  task automatic push_pop(input logic [23:0] l, input logic [23:0] r,
                          output logic [23:0] wl, output logic [23:0] wr, output bit ok);
    int n = 0;
    io.read_ready = 1'b1;
    io.readdata_left = l;
    io.readdata_right = r;
    do begin tick(); n++; end while (!io.read && n < 20);
    io.read_ready = 1'b0;
    ok = io.read;
    wl = '0;
    wr = '0;
    if (!ok) begin
      timeout("push_pop");
    end else begin
      io.write_ready = 1'b1;
      tick();
      io.write_ready = 1'b0;
      check("push_pop_write", io.write, 1);
      wl = io.writedata_left;
      wr = io.writedata_right;
    end
  endtask

  task automatic expect_data(input string name, input logic [23:0] l, input logic [23:0] r);
    logic [2*DW-1:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %0h/%0h, expected scoreboard entry (empty)", name, l, r);
    end else begin
      e = sb_q.pop_front();
      check(name, {l, r}, e);
    end
  endtask

  initial begin
    logic [23:0] gl, gr;
    bit ok;

    // op, L, R, zero write, state after, fill after
    vecs[0]  = '{1'b1, 24'd0, 24'd0,   1'b1, 2'd1, 4'd0};
    vecs[1]  = '{1'b0, 24'd1, 24'd101, 1'b0, 2'd1, 4'd1};
    vecs[2]  = '{1'b1, 24'd0, 24'd0,   1'b1, 2'd1, 4'd1};
    vecs[3]  = '{1'b0, 24'd2, 24'd102, 1'b0, 2'd1, 4'd2};
    vecs[4]  = '{1'b0, 24'd3, 24'd103, 1'b0, 2'd1, 4'd3};
    vecs[5]  = '{1'b0, 24'd4, 24'd104, 1'b0, 2'd2, 4'd4};
    vecs[6]  = '{1'b1, 24'd0, 24'd0,   1'b0, 2'd2, 4'd3};
    vecs[7]  = '{1'b1, 24'd0, 24'd0,   1'b0, 2'd2, 4'd2};
    vecs[8]  = '{1'b0, 24'd5, 24'd105, 1'b0, 2'd2, 4'd3};
    vecs[9]  = '{1'b1, 24'd0, 24'd0,   1'b0, 2'd2, 4'd2};
    vecs[10] = '{1'b1, 24'd0, 24'd0,   1'b0, 2'd2, 4'd1};
    vecs[11] = '{1'b1, 24'd0, 24'd0,   1'b0, 2'd2, 4'd0};
    vecs[12] = '{1'b1, 24'd0, 24'd0,   1'b1, 2'd1, 4'd0};

    io.read_ready = 1'b1;
    io.write_ready = 1'b1;
    io.readdata_left = '0;
    io.readdata_right = '0;

    // Reset held with both readies high
    repeat (4) tick();
    check("rst_read", io.read, 0);
    check("rst_write", io.write, 0);
    check("rst_state", st, 0);
    check("rst_fill", fill_level, 0);
    check("rst_counts", {overrun_count, underrun_count}, 0);
    check("rst_wdata", {io.writedata_left, io.writedata_right}, 0);
    resetn = 1'b1;
    repeat (4) tick();
    check("idle_no_strobe", {io.read, io.write}, 0);
    io.read_ready = 1'b0;
    io.write_ready = 1'b0;

    enable = 1'b1;
    tick();
    check("enter_prime", st, 1);

    // Priming, playback order and first underrun
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_dac) begin
        dac_take(gl, gr, ok);
        if (ok) begin
          if (vecs[i].exp_zero) check($sformatf("v%0d_zero", i), {gl, gr}, 0);
          else expect_data($sformatf("v%0d_data", i), gl, gr);
        end
      end else begin
        adc_send(vecs[i].l, vecs[i].r, ok);
        sb_q.push_back({vecs[i].l, vecs[i].r});
      end
      check($sformatf("v%0d_state", i), st, vecs[i].exp_state);
      check($sformatf("v%0d_fill", i), fill_level, vecs[i].exp_fill);
    end
    check("underrun_1", underrun_count, 1);
    check("no_overrun_yet", overrun_count, 0);

    // Re-prime, then fill to full with writes blocked
    for (int i = 6; i <= 13; i++) begin
      adc_send(24'(i), 24'(100 + i), ok);
      sb_q.push_back({24'(i), 24'(100 + i)});
      if (i == 9) check("reprime_run", st, 2);
    end
    check("full_fill", fill_level, 8);

    // Three pairs arriving at a full FIFO are dropped
    for (int i = 0; i < 3; i++) adc_send(24'(90 + i), 24'(190 + i), ok);
    check("ovr_fill", fill_level, 8);
    check("ovr_count", overrun_count, 3);

    // Push and pop on the same edge with the FIFO full
    push_pop(24'd20, 24'd120, gl, gr, ok);
    expect_data("full_pp_data", gl, gr);
    sb_q.push_back({24'd20, 24'd120});
    check("full_pp_fill", fill_level, 8);
    check("full_pp_ovr", overrun_count, 3);

    // Drain: contents must be untouched by the dropped pairs
    for (int i = 0; i < 8; i++) begin
      dac_take(gl, gr, ok);
      if (ok) expect_data($sformatf("drain%0d", i), gl, gr);
    end
    check("drain_fill", fill_level, 0);
    check("drain_state", st, 2);

    // Push and pop on the same edge with the FIFO empty
    push_pop(24'd30, 24'd130, gl, gr, ok);
    check("empty_pp_zero", {gl, gr}, 0);
    sb_q.push_back({24'd30, 24'd130});
    check("empty_pp_und", underrun_count, 2);
    check("empty_pp_fill", fill_level, 1);
    check("empty_pp_state", st, 1);

    for (int i = 31; i <= 33; i++) begin
      adc_send(24'(i), 24'(100 + i), ok);
      sb_q.push_back({24'(i), 24'(100 + i)});
    end
    check("reprime2_state", st, 2);
    dac_take(gl, gr, ok);
    if (ok) expect_data("after_pp_data", gl, gr);
    for (int i = 34; i <= 35; i++) adc_send(24'(i), 24'(100 + i), ok);
    check("pre_disable_fill", fill_level, 5);

    // Disable mid-stream: flush, keep counters and DAC data
    enable = 1'b0;
    tick();
    sb_q.delete();
    check("dis_state", st, 0);
    check("dis_fill", fill_level, 0);
    check("dis_counts", {overrun_count, underrun_count}, {16'd3, 16'd2});
    check("dis_wdata", {io.writedata_left, io.writedata_right}, {24'd30, 24'd130});
    repeat (2) tick();
    check("dis_no_strobe", {io.read, io.write}, 0);

    // Asynchronous reset during a write strobe
    enable = 1'b1;
    tick();
    dac_take(gl, gr, ok);
    check("pre_rst_write", io.write, 1);
    resetn = 1'b0;
    #1;
    check("async_rst_write", io.write, 0);
    check("async_rst_counts", {overrun_count, underrun_count}, 0);
    check("async_rst_state", st, 0);
    tick();
    resetn = 1'b1;
    enable = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_stream_ctrl.md
# audio_stream_ctrl

Handshake sequencer and elastic buffer between the audio CODEC's ADC read port and its DAC write port. It replaces a direct combinational loopback of `readdata_*` to `writedata_*`: it issues single-cycle `read`/`write` strobes and buffers stereo samples in a small FIFO. It primes the FIFO before playback and reports overrun/underrun events. It sits between the top level and `audio_codec`, and future DSP blocks are inserted on its FIFO path.

## Interface
Parameters:
- `DW`, 24, sample width per channel
- `DEPTH`, 8, FIFO depth in stereo sample pairs; power of 2, ≥ 4
- `PRIME_LEVEL`, 4, fill level required before playback starts; 1 ≤ PRIME_LEVEL ≤ DEPTH

Ports:
- `CLOCK_50`  in  1  the single system clock; all logic on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `enable`  in  1  run request; low forces IDLE and flushes the FIFO
- `read_ready`  in  1  CODEC has an ADC sample pair available
- `write_ready`  in  1  CODEC can accept a DAC sample pair
- `readdata_left` / `readdata_right`  in  DW  ADC samples from the CODEC
- `read`  out  1  one-cycle strobe; consumes the ADC sample pair
- `write`  out  1  one-cycle strobe; presents `writedata_*` to the CODEC
- `writedata_left` / `writedata_right`  out  DW  registered DAC samples
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- `overrun_count`  out  16  saturating count of dropped ADC pairs
- `underrun_count`  out  16  saturating count of zero-filled DAC writes
- `state`  out  2  encoding: 0 = IDLE, 1 = PRIME, 2 = RUN

## Operation
- **Reset values.** All outputs are 0, FIFO pointers are 0, and `state` = IDLE.
- **IDLE**
  - No strobes are issued; the FIFO is held empty.
  - Moves to PRIME when `enable` = 1.
- **PRIME**
  - ADC pairs are accepted into the FIFO.
  - DAC write requests are served with zeros. These are not counted as underruns.
  - Moves to RUN on the edge where `fill_level` (after this cycle's push) ≥ PRIME_LEVEL.
- **RUN**
  - ADC pairs are pushed and DAC writes pop the FIFO head.
  - A write request with an empty FIFO is an underrun:
    - it writes zeros;
    - it increments `underrun_count`;
    - the state returns to PRIME.
- **Any state → IDLE when `enable` = 0.**
  - The FIFO is flushed on that edge and `fill_level` = 0.
  - A strobe already asserted completes its single cycle.
  - No new strobe starts.
  - Counters and `writedata_*` are retained.
- **Read sequencing**
  - In PRIME/RUN, `read_ready` = 1 with `read` = 0 sampled at edge k asserts `read` for the cycle after edge k, which ends at edge k+1.
  - The pair on `readdata_*` is captured at edge k+1.
  - `read` never asserts in two consecutive cycles.
- **Overrun**
  - The ADC is always drained so the CODEC never stalls.
  - If the FIFO is full at capture and no pop occurs on the same edge:
    - the pair is dropped;
    - `overrun_count` increments.
- **Write sequencing**
  - In PRIME/RUN, `write_ready` = 1 with `write` = 0 sampled at edge k does the following at edge k:
    - `writedata_*` is loaded, from the FIFO head (RUN, non-empty) or with zeros;
    - `write` = 1 for the following cycle only.
  - `writedata_*` holds its value until the next write load.
- **Simultaneous push and pop**
  - `fill_level` is unchanged.
  - A full FIFO with a same-edge pop accepts the push; this is not an overrun.
  - An empty FIFO with a same-edge push in RUN is still an underrun. The pushed pair is stored, `fill_level` = 1, and the state goes to PRIME.
- **Counters** saturate at 16'hFFFF and clear only on reset.
- **Width.** `fill_level` is computed as write pointer minus read pointer using pointers one bit wider than the address, so full and empty are distinguishable when the pointers wrap.

## Timing
- **ADC-to-DAC latency.** The minimum is one write request after the priming pair is pushed, which is PRIME_LEVEL pairs of pre-buffer.
- **Strobe response.** Strobes rise one edge after the ready is sampled. Ready-to-strobe latency is fixed at 1 cycle.
- **FIFO storage.** FIFO read data is available to the write-load path on the same edge as the pop. Use registered storage with a look-ahead head or an equivalent structure; there is no extra cycle.
- **Reset.** Asynchronous assertion clears all state immediately, including any in-flight strobe. Deassertion is synchronized externally.

## Test plan
- **Reset.** Hold `resetn` = 0 with `read_ready` = `write_ready` = 1 → `read` = `write` = 0, all outputs 0, `state` = 0. Release with `enable` = 0 → still no strobes.
- **Priming.** Set `enable` = 1, PRIME_LEVEL = 4, and push pairs L=1..4 / R=101..104 while serving writes.
  - During PRIME, `write` strobes carry 0/0.
  - After the 4th capture, `state` = 2.
  - The next write outputs 1/101, then 2/102, in order.
- **Overrun.** Fill to DEPTH = 8 with writes blocked, then send 3 more read_ready events → 3 `read` strobes, `fill_level` stays 8, `overrun_count` = 3, and FIFO contents are unchanged.
- **Underrun.** In RUN, drain to empty, then raise `write_ready` → zeros are written, `underrun_count` = 1, `state` = 1. Re-prime with 4 pairs → back to RUN.
- **Simultaneous push/pop.** With FIFO full in RUN, read and write strobes fall on the same edge → `fill_level` stays 8 and there is no overrun. Repeat on an empty FIFO → underrun counted and `fill_level` = 1.
- **Disable/reset mid-stream.**
  - Drop `enable` at `fill_level` = 5 → next cycle `state` = 0, `fill_level` = 0, counters retained.
  - Assert `resetn` = 0 during a `write` strobe → `write` falls immediately and counters clear.
